// File: rtl/root_n_seq.sv
// root_n_seq: sequential integer n-th root, res = floor(arg^(1/n)).
// The result is built one bit at a time, MSB first. For each bit a trial
// candidate is raised to the n-th power with one iterative multiplier.
// The candidate's bit is kept when that power does not exceed the operand.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   arg_vld  in   operand valid
//   arg      in   [w-1:0] unsigned radicand
//   arg_rdy  out  operand accepted when high (IDLE only)
//   res_vld  out  result valid, held until res_rdy
//   res      out  [r-1:0] root; meaningful only while res_vld is high
//   res_rdy  in   downstream accepts result
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand, arg_rdy high
// TRY   | form the candidate root | (1<<k), seed the product with it
// MUL   | prod *= cand, repeated n-1 times to reach cand^n
// CMP   | keep the candidate bit if cand^n <= arg, step to next bit
// DONE  | present the result until the downstream accepts it
module root_n_seq #(
    parameter int w = 8,
    parameter int n = 5,
    localparam int r = (w + n - 1) / n
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arg_vld,
    input  logic [w-1:0] arg,
    output logic         arg_rdy,
    output logic         res_vld,
    output logic [r-1:0] res,
    input  logic         res_rdy
);

    localparam int PW = r * n;
    localparam int KW = (r > 1) ? $clog2(r) : 1;
    localparam int CW = $clog2(n + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRY,
        S_MUL,
        S_CMP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [w-1:0]    arg_q,   arg_d;
    logic [r-1:0]    root_q,  root_d;
    logic [r-1:0]    cand_q,  cand_d;
    logic [PW-1:0]   prod_q,  prod_d;
    logic [KW-1:0]   k_q,     k_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic [r-1:0]    trial;
    logic [CW-1:0]   cnt_inc;
    logic [PW-1:0]   mul_tr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            arg_q   <= '0;
            root_q  <= '0;
            cand_q  <= '0;
            prod_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            root_q  <= root_d;
            cand_q  <= cand_d;
            prod_q  <= prod_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        root_d  = root_q;
        cand_d  = cand_q;
        prod_d  = prod_q;
        k_d     = k_q;
        cnt_d   = cnt_q;

        trial   = root_q | (r'(1) << k_q);
        cnt_inc = cnt_q + 1'b1;
        // cand < 2^r so cand^n fits in r*n bits; truncation never loses bits.
        mul_tr  = prod_q * PW'(cand_q);

        unique case (state_q)
            S_IDLE: begin
                if (arg_vld) begin
                    arg_d   = arg;
                    root_d  = '0;
                    k_d     = KW'(r - 1);
                    state_d = S_TRY;
                end
            end
            S_TRY: begin
                cand_d  = trial;
                prod_d  = PW'(trial);
                cnt_d   = CW'(1);
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d = mul_tr;
                cnt_d  = cnt_inc;
                if (cnt_inc == CW'(n)) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (prod_q <= PW'(arg_q)) begin
                    root_d = cand_q;
                end
                if (k_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q - 1'b1;
                    state_d = S_TRY;
                end
            end
            S_DONE: begin
                if (res_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign arg_rdy = (state_q == S_IDLE);
    assign res_vld = (state_q == S_DONE);
    assign res     = root_q;

endmodule

// File: tb/tb_root_n_seq.sv
module tb_root_n_seq;

    localparam int LAT = 12;

    logic       clk;
    logic       rst;

    logic       arg_vld_a, arg_rdy_a, res_vld_a, res_rdy_a;
    logic [7:0] arg_a;
    logic [1:0] res_a;

    logic       arg_vld_b, arg_rdy_b, res_vld_b, res_rdy_b;
    logic [7:0] arg_b;
    logic [3:0] res_b;

    root_n_seq #(.w(8), .n(5)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld_a),
        .arg     (arg_a),
        .arg_rdy (arg_rdy_a),
        .res_vld (res_vld_a),
        .res     (res_a),
        .res_rdy (res_rdy_a)
    );

    root_n_seq #(.w(8), .n(2)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld_b),
        .arg     (arg_b),
        .arg_rdy (arg_rdy_b),
        .res_vld (res_vld_b),
        .res     (res_b),
        .res_rdy (res_rdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint ipow(input longint x, input int e);
        longint p = 1;
        for (int i = 0; i < e; i++) p = p * x;
        return p;
    endfunction

    function automatic int ref_root(input int a, input int e);
        int x = 0;
        while (ipow(longint'(x + 1), e) <= longint'(a)) x++;
        return x;
    endfunction

    // scoreboards: expected roots pushed on acceptance
    int q_a[$];
    int q_b[$];
    int acc_edge_a = 0;
    int hs_a       = 0;
    bit busy_a     = 0;
    bit prev_vld_a = 0;
    int prev_res_a = 0;

    // DUT A output monitor
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            busy_a     = 0;
            prev_vld_a = 0;
        end else begin
            if (busy_a) check("arg_rdy_low_busy", int'(arg_rdy_a), 0);
            if (arg_vld_a && arg_rdy_a) busy_a = 1;
            if (res_vld_a && !prev_vld_a) check("latency_a", cyc - acc_edge_a, LAT);
            if (res_vld_a && prev_vld_a) check("res_stable_a", int'(res_a), prev_res_a);
            if (res_vld_a && res_rdy_a) begin
                if (q_a.size() == 0) begin
                    check("unexpected_result_a", 1, 0);
                end else begin
                    check("res_a", int'(res_a), q_a.pop_front());
                end
                hs_a++;
                busy_a = 0;
            end
            prev_vld_a = res_vld_a;
            prev_res_a = int'(res_a);
        end
    end

    task automatic drive_a(input int a, input int e);
        bit ok = 0;
        arg_vld_a = 1'b1;
        arg_a     = 8'(a);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (arg_rdy_a) ok = 1;
        end
        if (!ok) begin
            check("accept_timeout_a", 0, 1);
        end else begin
            q_a.push_back(e);
            acc_edge_a = cyc + 1;
            @(posedge clk);
            #1;
        end
        arg_vld_a = 1'b0;
    endtask

    task automatic wait_hs_a(input int target);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (hs_a >= target) ok = 1;
        end
        if (!ok) check("result_timeout_a", hs_a, target);
    endtask

    task automatic run_b(input int a, input int e);
        bit ok = 0;
        int acc;
        arg_vld_b = 1'b1;
        arg_b     = 8'(a);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (arg_rdy_b) ok = 1;
        end
        if (!ok) begin
            check("accept_timeout_b", 0, 1);
            arg_vld_b = 1'b0;
            return;
        end
        q_b.push_back(e);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        arg_vld_b = 1'b0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (res_vld_b) ok = 1;
        end
        if (!ok) begin
            check("result_timeout_b", 0, 1);
            q_b.delete();
            return;
        end
        check("latency_b", cyc - acc, LAT);
        check("res_b", int'(res_b), q_b.pop_front());
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int a;
        int e;
    } vec_t;

    vec_t vec_a[6];
    vec_t vec_b[4];

    initial begin
        int base;
        int c;
        bit ok;

        vec_a[0] = '{0, 0};
        vec_a[1] = '{31, 1};
        vec_a[2] = '{32, 2};
        vec_a[3] = '{242, 2};
        vec_a[4] = '{243, 3};
        vec_a[5] = '{255, 3};
        vec_b[0] = '{255, 15};
        vec_b[1] = '{144, 12};
        vec_b[2] = '{143, 11};
        vec_b[3] = '{1, 1};

        rst       = 1'b1;
        arg_vld_a = 1'b0;
        arg_a     = '0;
        res_rdy_a = 1'b1;
        arg_vld_b = 1'b0;
        arg_b     = '0;
        res_rdy_b = 1'b1;

        #12;
        check("reset_arg_rdy_a", int'(arg_rdy_a), 1);
        check("reset_res_vld_a", int'(res_vld_a), 0);
        check("reset_res_a",     int'(res_a),     0);
        check("reset_arg_rdy_b", int'(arg_rdy_b), 1);
        check("reset_res_vld_b", int'(res_vld_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // directed table, n=5
        for (int i = 0; i < 6; i++) begin
            base = hs_a;
            drive_a(vec_a[i].a, vec_a[i].e);
            wait_hs_a(base + 1);
        end

        // exhaustive sweep against the brute-force reference, back to back
        base = hs_a;
        for (int a = 0; a < 256; a++) drive_a(a, ref_root(a, 5));
        wait_hs_a(base + 256);

        // backpressure: result held, new operand refused until handshake
        res_rdy_a = 1'b0;
        drive_a(100, 2);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (res_vld_a) ok = 1;
        end
        check("bp_res_vld_seen", int'(ok), 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            arg_vld_a = 1'b1;
            arg_a     = 8'd200;
            @(negedge clk);
            check("bp_res_vld_hold", int'(res_vld_a), 1);
            check("bp_res_hold",     int'(res_a),     2);
            check("bp_arg_rdy_low",  int'(arg_rdy_a), 0);
        end
        @(posedge clk);
        #1;
        c = cyc;
        base = hs_a;
        res_rdy_a = 1'b1;
        drive_a(200, 2);
        check("bp_accept_edge", acc_edge_a, c + 2);
        wait_hs_a(base + 2);

        // parameter variant n=2
        for (int i = 0; i < 4; i++) run_b(vec_b[i].a, vec_b[i].e);
        for (int a = 0; a < 256; a += 17) run_b(a, ref_root(a, 2));

        // reset in the middle of a computation
        drive_a(243, 3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_res_vld", int'(res_vld_a), 0);
        check("rst_res",     int'(res_a),     0);
        check("rst_arg_rdy", int'(arg_rdy_a), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = hs_a;
        drive_a(32, 2);
        wait_hs_a(base + 1);

        // operand lines toggled while busy must be ignored
        base = hs_a;
        drive_a(243, 3);
        for (int i = 0; i < 11; i++) begin
            arg_vld_a = ~arg_vld_a;
            arg_a     = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        arg_vld_a = 1'b0;
        wait_hs_a(base + 1);
        repeat (20) @(posedge clk);
        #1;
        check("toggle_one_handshake", hs_a - base, 1);
        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
